// File: rtl/rf_sb.sv
// Two-write / two-read register file with a per-register scoreboard of pending
// producers. Reads and busy flags bypass same-cycle writes combinationally.
module rf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic wv0_s;
  logic wv1_s;
  logic iss_ok_s;

  // Register 0 is read-only (constant zero) when ZERO_REG is set.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG && (a == {ADDR_W{1'b0}}));
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    if (!writable(ra)) begin
      v = {DATA_W{1'b0}};
    end else if (wv1_s && (wa1 == ra)) begin
      v = wd1;
    end else if (wv0_s && (wa0 == ra)) begin
      v = wd0;
    end else begin
      v = regs_q[ra];
    end
    return v;
  endfunction

  function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
    logic hit;
    hit = (wv0_s && (wa0 == ra)) || (wv1_s && (wa1 == ra));
    return writable(ra) && pend_q[ra] && !hit;
  endfunction

  assign wv0_s    = we0 && writable(wa0);
  assign wv1_s    = we1 && writable(wa1);
  assign iss_ok_s = iss_en && writable(iss_rd);

  // Next state: port 1 wins write collisions; a new issue beats a completing write; flush beats issue.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (wv1_s && (wa1 == ADDR_W'(i))) ? wd1 :
                  (wv0_s && (wa0 == ADDR_W'(i))) ? wd0 : regs_q[i];
      pend_d[i] = flush                                   ? 1'b0 :
                  (iss_ok_s && (iss_rd == ADDR_W'(i)))    ? 1'b1 :
                  ((wv0_s && (wa0 == ADDR_W'(i))) ||
                   (wv1_s && (wa1 == ADDR_W'(i))))        ? 1'b0 : pend_q[i];
    end
  end

  // State registers with synchronous reset overriding all same-cycle updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      pend_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Combinational read and scoreboard ports.
  always_comb begin
    rd1   = read_port(ra1);
    rd2   = read_port(ra2);
    busy1 = busy_port(ra1);
    busy2 = busy_port(ra2);
  end

endmodule

// File: tb/tb_rf_sb.sv
// Self-checking bench for rf_sb: directed vectors with literal expectations plus a
// per-cycle comparison against an abstract register/scoreboard model.
module tb_rf_sb;

  logic        clk = 1'b0;
  logic        rst, we0, we1, iss_en, flush;
  logic [4:0]  wa0, wa1, ra1, ra2, iss_rd;
  logic [31:0] wd0, wd1, rd1, rd2;
  logic        busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  logic [31:0] m_regs [32];
  logic        m_pend [32];

  rf_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what a register holds after this edge, applying the cycle's events in time order.
  function automatic logic [31:0] next_reg(input int i);
    logic [4:0]  a = 5'(i);
    logic [31:0] v = m_regs[i];
    if (a != 5'd0) begin
      if (we0 && wa0 == a) v = wd0;
      if (we1 && wa1 == a) v = wd1;
    end
    if (rst) v = 32'd0;
    return v;
  endfunction

  function automatic logic next_pend(input int i);
    logic [4:0] a = 5'(i);
    logic       v = m_pend[i];
    if (a != 5'd0) begin
      if ((we0 && wa0 == a) || (we1 && wa1 == a)) v = 1'b0;
      if (iss_en && iss_rd == a) v = 1'b1;
    end
    if (flush) v = 1'b0;
    if (rst)   v = 1'b0;
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    logic [31:0] v;
    if (ra == 5'd0) return 32'd0;
    v = m_regs[ra];
    if (we0 && wa0 == ra) v = wd0;
    if (we1 && wa1 == ra) v = wd1;
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    return m_pend[ra] && !(we0 && wa0 == ra) && !(we1 && wa1 == ra);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] <= next_reg(i);
      m_pend[i] <= next_pend(i);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_rd1",   rd1,           exp_rd(ra1));
      chk("model_rd2",   rd2,           exp_rd(ra2));
      chk("model_busy1", {31'd0, busy1}, {31'd0, exp_busy(ra1)});
      chk("model_busy2", {31'd0, busy2}, {31'd0, exp_busy(ra2)});
    end
  end

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; flush = 1'b0;
    wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
    ra1 = 5'd0; ra2 = 5'd0; iss_rd = 5'd0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h1234;
    adv();
    chk_on = 1'b1;
    rst = 1'b1;
    adv();

    // Reset state
    ra1 = 5'd6; ra2 = 5'd5; settle();
    chk("reset_rd1",   rd1, 32'd0);
    chk("reset_busy2", {31'd0, busy2}, 32'd0);
    adv();

    // Bypass then stored
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5; settle();
    chk("bypass_rd1", rd1, 32'hDEADBEEF);
    adv();
    ra1 = 5'd5; settle();
    chk("stored_rd1", rd1, 32'hDEADBEEF);
    adv();

    // Port 1 priority
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22; ra1 = 5'd3;
    settle();
    chk("prio_bypass", rd1, 32'h22);
    adv();
    ra1 = 5'd3; settle();
    chk("prio_stored", rd1, 32'h22);
    adv();

    // Zero register
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra2 = 5'd0; settle();
    chk("zero_bypass", rd2, 32'd0);
    adv();
    ra2 = 5'd0; iss_en = 1'b1; iss_rd = 5'd0; settle();
    chk("zero_stored", rd2, 32'd0);
    chk("zero_busy_same", {31'd0, busy2}, 32'd0);
    adv();
    ra2 = 5'd0; settle();
    chk("zero_busy_next", {31'd0, busy2}, 32'd0);
    adv();

    // Issue then writeback
    iss_en = 1'b1; iss_rd = 5'd7; adv();
    ra1 = 5'd7; settle();
    chk("pend7_busy", {31'd0, busy1}, 32'd1);
    adv();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h77; ra1 = 5'd7; settle();
    chk("wb7_busy", {31'd0, busy1}, 32'd0);
    chk("wb7_rd",   rd1, 32'h77);
    adv();
    ra1 = 5'd7; settle();
    chk("after7_busy", {31'd0, busy1}, 32'd0);
    adv();

    // Same-cycle set and clear, then flush
    iss_en = 1'b1; iss_rd = 5'd9; adv();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99; iss_en = 1'b1; iss_rd = 5'd9; ra2 = 5'd9; settle();
    chk("setclr_busy_same", {31'd0, busy2}, 32'd0);
    adv();
    ra2 = 5'd9; settle();
    chk("setclr_busy_next", {31'd0, busy2}, 32'd1);
    adv();
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd10; ra2 = 5'd9; adv();
    ra2 = 5'd9; ra1 = 5'd10; settle();
    chk("flush_busy9",  {31'd0, busy2}, 32'd0);
    chk("flush_busy10", {31'd0, busy1}, 32'd0);
    chk("flush_keep9",  rd2, 32'h99);
    adv();

    // Reset mid-operation
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h101; we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h102; adv();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h103; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h104; adv();
    iss_en = 1'b1; iss_rd = 5'd4; adv();
    ra1 = 5'd4; settle();
    chk("pre_rst_busy4", {31'd0, busy1}, 32'd1);
    chk("pre_rst_rd4",   rd1, 32'h104);
    adv();
    rst = 1'b1; we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h55; iss_en = 1'b1; iss_rd = 5'd3; ra1 = 5'd2;
    settle();
    chk("rst_comb_bypass", rd1, 32'h55);
    adv();
    for (int i = 1; i <= 4; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); settle();
      chk("post_rst_rd1",   rd1, 32'd0);
      chk("post_rst_busy2", {31'd0, busy2}, 32'd0);
      adv();
    end

    // Random traffic with a narrow address range to force collisions
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 59) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      iss_en = 1'($urandom_range(0, 1));
      wa0    = 5'($urandom_range(0, 7));
      wa1    = 5'($urandom_range(0, 7));
      iss_rd = 5'($urandom_range(0, 7));
      ra1    = 5'($urandom_range(0, 7));
      ra2    = (c % 5 == 0) ? ra1 : 5'($urandom_range(0, 7));
      wd0    = $urandom;
      wd1    = $urandom;
      @(posedge clk); #1;
    end
    idle();
    settle();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_sb.md
RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set register and data-port width.
REQ-002 Parameter ADDR_W, default 5, SHALL set address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, SHALL make register 0 hard-wired zero when 1; ordinary register when 0.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Ports we0/we1, input, 1: write enables, write ports 0 and 1.
REQ-007 Ports wa0/wa1, input, ADDR_W: write addresses.
REQ-008 Ports wd0/wd1, input, DATA_W: write data.
REQ-009 Ports ra1/ra2, input, ADDR_W: read addresses.
REQ-010 Ports rd1/rd2, output, DATA_W: read data, combinational.
REQ-011 Ports busy1/busy2, output, 1: scoreboard pending flag for ra1/ra2, combinational.
REQ-012 Port iss_en, input, 1: issue strobe; marks iss_rd pending.
REQ-013 Port iss_rd, input, ADDR_W: destination register of issued instruction.
REQ-014 Port flush, input, 1: clears all pending flags; register contents untouched.

Function
REQ-015 Storage SHALL be depth x DATA_W registers plus depth pending bits, written on rising clk only.
REQ-016 Write port k SHALL update reg[wak] <= wdk at the edge when wek=1 and wak is writable (not reg 0 when ZERO_REG=1).
REQ-017 Same-cycle we0 and we1 to the same address SHALL store wd1 (port 1 priority).
REQ-018 Read rdN SHALL return 0 when raN=0 and ZERO_REG=1, regardless of writes.
REQ-019 Read rdN SHALL bypass: if we1 and wa1==raN, return wd1; else if we0 and wa0==raN, return wd0; else stored value.
REQ-020 Writes to reg 0 with ZERO_REG=1 SHALL be discarded and never bypassed.
REQ-021 Valid write on port k SHALL clear pending[wak] at the edge.
REQ-022 iss_en=1 SHALL set pending[iss_rd] at the edge; iss_rd=0 with ZERO_REG=1 SHALL be ignored.
REQ-023 Set and clear of the same pending bit in the same cycle SHALL leave it set (new producer wins).
REQ-024 flush=1 SHALL clear all pending bits at the edge and override same-cycle iss_en; same-cycle writes SHALL still update registers.
REQ-025 busyN SHALL equal pending[raN] AND NOT (a valid write to raN this cycle); busyN=0 for reg 0 when ZERO_REG=1.
REQ-026 Read ports SHALL be fully independent; ra1==ra2 yields identical outputs.
REQ-027 Latency: write/issue visible in stored state one edge later; visible on rd/busy same cycle via bypass.

Reset
REQ-028 rst=1 at a rising edge SHALL clear every register to 0 and every pending bit to 0, overriding same-cycle writes, issue and flush.
REQ-029 During rst, rd/busy SHALL still follow REQ-018..REQ-025 combinationally; after release all reads return 0, busy 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending state; no partial state survives.

Verification
REQ-031 Reset, then we0=1 wa0=5 wd0=0xDEADBEEF, ra1=5 same cycle -> rd1=0xDEADBEEF (bypass); next cycle with we0=0 -> rd1=0xDEADBEEF (stored).
REQ-032 we0 wa0=3 wd0=0x11 and we1 wa1=3 wd1=0x22 same cycle -> rd1=0x22 that cycle and after.
REQ-033 ZERO_REG=1: we1 wa1=0 wd1=0xFFFFFFFF, ra2=0 -> rd2=0 that cycle and next; iss_en iss_rd=0 -> busy2=0.
REQ-034 iss_en iss_rd=7; next cycle ra1=7 -> busy1=1; cycle with we0 wa0=7 -> busy1=0, rd1=wd0; following cycle busy1=0.
REQ-035 Pending reg 9; same cycle we1 wa1=9 and iss_en iss_rd=9 -> next cycle busy for 9 = 1; then flush=1 -> next cycle busy=0, reg 9 retains written value.
REQ-036 Regs 1..4 written, reg 4 pending, rst=1 with we0 wa0=2 -> next cycle all reads 0, all busy 0.
